// File: rtl/i2c_reg_master.sv
// I2C single-register initiator: START, dev addr, reg index, then write data or RSTART + read byte, STOP.
// Latency accept->rsp_valid: write 116*Q+1, read 156*Q+1, address NACK 44*Q+1 cycles (Q = C_QDIV).
// Backpressure: cmd_ready is high only in IDLE; cmd_valid is ignored while a transaction is running.
module i2c_reg_master #(
  parameter int C_QDIV = 63
) (
  input  logic       soc_clk,
  input  logic       aresetn,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rw,
  input  logic [6:0] cmd_dev_addr,
  input  logic [7:0] cmd_reg,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_nack,
  output logic       scl_t,
  output logic       sda_t,
  input  logic       sda_i
);

  localparam int TW = (C_QDIV > 1) ? $clog2(C_QDIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(C_QDIV - 1);

  typedef enum logic [3:0] {
    IDLE, START, TX_BIT, TX_ACK, RSTART, RX_BIT, M_NACK, STOP, DONE
  } state_t;

  typedef enum logic [1:0] {SEL_ADDR_W, SEL_REG, SEL_WDATA, SEL_ADDR_R} sel_t;

  state_t          state;
  sel_t            sel;
  logic [1:0]      qtr;
  logic [TW-1:0]   tick;
  logic [2:0]      bit_cnt;
  logic [7:0]      tx_sh;
  logic [7:0]      rx_sh;
  logic            rw;
  logic [6:0]      dev;
  logic [7:0]      reg_idx;
  logic [7:0]      wdata;
  logic            nack;
  logic            quarter_end;

  assign quarter_end = (tick == TICK_LAST);

  // Pad enables {scl, sda} for a given phase and quarter; b is the data bit for TX_BIT.
  function automatic logic [1:0] lines(input state_t s, input logic [1:0] q, input logic b);
    lines = 2'b11;
    case (s)
      START:  lines = (q == 2'd3) ? 2'b00 : (q == 2'd2) ? 2'b10 : 2'b11;
      TX_BIT: lines = {q[1], b};
      TX_ACK, RX_BIT, M_NACK: lines = {q[1], 1'b1};
      RSTART: begin
        case (q)
          2'd0:    lines = 2'b01;
          2'd1:    lines = 2'b11;
          2'd2:    lines = 2'b10;
          default: lines = 2'b00;
        endcase
      end
      STOP: begin
        case (q)
          2'd0:    lines = 2'b00;
          2'd1:    lines = 2'b10;
          default: lines = 2'b11;
        endcase
      end
      default: lines = 2'b11;
    endcase
  endfunction

  always_ff @(posedge soc_clk) begin
    if (!aresetn) begin
      state     <= IDLE;
      sel       <= SEL_ADDR_W;
      qtr       <= 2'd0;
      tick      <= '0;
      bit_cnt   <= 3'd0;
      tx_sh     <= 8'h00;
      rx_sh     <= 8'h00;
      rw        <= 1'b0;
      dev       <= 7'h00;
      reg_idx   <= 8'h00;
      wdata     <= 8'h00;
      nack      <= 1'b0;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 8'h00;
      rsp_nack  <= 1'b0;
      scl_t     <= 1'b1;
      sda_t     <= 1'b1;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            state     <= START;
            rw        <= cmd_rw;
            dev       <= cmd_dev_addr;
            reg_idx   <= cmd_reg;
            wdata     <= cmd_wdata;
            qtr       <= 2'd0;
            tick      <= '0;
            nack      <= 1'b0;
            rx_sh     <= 8'h00;
            cmd_ready <= 1'b0;
          end
        end
        DONE: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
        end
        default: begin
          tick <= quarter_end ? '0 : tick + 1'b1;
          if (quarter_end) begin
            qtr <= qtr + 2'd1;
            // SDA is sampled on the last cycle of the first SCL-high quarter.
            if (qtr == 2'd2 && state == TX_ACK && sda_i) nack <= 1'b1;
            if (qtr == 2'd2 && state == RX_BIT) rx_sh <= {rx_sh[6:0], sda_i};
            if (qtr != 2'd3) begin
              {scl_t, sda_t} <= lines(state, qtr + 2'd1, tx_sh[7]);
            end else begin
              case (state)
                START: begin
                  state          <= TX_BIT;
                  sel            <= SEL_ADDR_W;
                  bit_cnt        <= 3'd0;
                  tx_sh          <= {dev, 1'b0};
                  {scl_t, sda_t} <= lines(TX_BIT, 2'd0, dev[6]);
                end
                TX_BIT: begin
                  if (bit_cnt == 3'd7) begin
                    state          <= TX_ACK;
                    {scl_t, sda_t} <= lines(TX_ACK, 2'd0, 1'b1);
                  end else begin
                    bit_cnt        <= bit_cnt + 3'd1;
                    tx_sh          <= {tx_sh[6:0], 1'b0};
                    {scl_t, sda_t} <= lines(TX_BIT, 2'd0, tx_sh[6]);
                  end
                end
                TX_ACK: begin
                  if (nack || sel == SEL_WDATA) begin
                    state          <= STOP;
                    {scl_t, sda_t} <= lines(STOP, 2'd0, 1'b1);
                  end else if (sel == SEL_ADDR_W) begin
                    state          <= TX_BIT;
                    sel            <= SEL_REG;
                    bit_cnt        <= 3'd0;
                    tx_sh          <= reg_idx;
                    {scl_t, sda_t} <= lines(TX_BIT, 2'd0, reg_idx[7]);
                  end else if (sel == SEL_REG && rw) begin
                    state          <= RSTART;
                    {scl_t, sda_t} <= lines(RSTART, 2'd0, 1'b1);
                  end else if (sel == SEL_REG) begin
                    state          <= TX_BIT;
                    sel            <= SEL_WDATA;
                    bit_cnt        <= 3'd0;
                    tx_sh          <= wdata;
                    {scl_t, sda_t} <= lines(TX_BIT, 2'd0, wdata[7]);
                  end else begin
                    state          <= RX_BIT;
                    bit_cnt        <= 3'd0;
                    {scl_t, sda_t} <= lines(RX_BIT, 2'd0, 1'b1);
                  end
                end
                RSTART: begin
                  state          <= TX_BIT;
                  sel            <= SEL_ADDR_R;
                  bit_cnt        <= 3'd0;
                  tx_sh          <= {dev, 1'b1};
                  {scl_t, sda_t} <= lines(TX_BIT, 2'd0, dev[6]);
                end
                RX_BIT: begin
                  if (bit_cnt == 3'd7) begin
                    state          <= M_NACK;
                    {scl_t, sda_t} <= lines(M_NACK, 2'd0, 1'b1);
                  end else begin
                    bit_cnt        <= bit_cnt + 3'd1;
                    {scl_t, sda_t} <= lines(RX_BIT, 2'd0, 1'b1);
                  end
                end
                M_NACK: begin
                  state          <= STOP;
                  {scl_t, sda_t} <= lines(STOP, 2'd0, 1'b1);
                end
                STOP: begin
                  state          <= DONE;
                  rsp_valid      <= 1'b1;
                  rsp_nack       <= nack;
                  rsp_rdata      <= nack ? 8'h00 : rx_sh;
                  {scl_t, sda_t} <= 2'b11;
                end
                default: begin
                  state          <= IDLE;
                  {scl_t, sda_t} <= 2'b11;
                end
              endcase
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_reg_master.sv
// Bench for i2c_reg_master: behavioural I2C slave on the pads plus a transaction-level
// reference model predicting bus events, response fields and latency.
module tb_i2c_reg_master;

  localparam int QDIV = 4;
  localparam logic [6:0] SLAVE_ADDR = 7'h2A;
  localparam int EV_S = 'h100;
  localparam int EV_P = 'h200;
  localparam int EV_A = 'h400;

  logic       soc_clk = 1'b0;
  logic       aresetn = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_rw = 1'b0;
  logic [6:0] cmd_dev_addr = 7'h00;
  logic [7:0] cmd_reg = 8'h00;
  logic [7:0] cmd_wdata = 8'h00;
  logic       cmd_ready, rsp_valid, rsp_nack, scl_t, sda_t, sda_i;
  logic [7:0] rsp_rdata;
  logic       slv_sda = 1'b1;

  assign sda_i = sda_t & slv_sda;

  always #5 soc_clk = ~soc_clk;

  i2c_reg_master #(.C_QDIV(QDIV)) dut (
    .soc_clk(soc_clk), .aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
    .cmd_dev_addr(cmd_dev_addr), .cmd_reg(cmd_reg), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_nack(rsp_nack),
    .scl_t(scl_t), .sda_t(sda_t), .sda_i(sda_i)
  );

  int n_chk = 0;
  int n_fail = 0;
  int rsp_cnt = 0;
  int bus_log[$];
  int exp_log[$];
  logic [7:0] slave_mem [256];
  logic [7:0] ref_mem [256];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge soc_clk) if (rsp_valid === 1'b1) rsp_cnt++;

  // Behavioural slave: decodes START/STOP and bytes from line levels, logs every bus event.
  logic       pscl = 1'b1, psda = 1'b1, rd_act = 1'b0, addressed = 1'b0;
  int         bitn = 0, bidx = 0;
  logic [7:0] sh = 8'h00, tx = 8'h00, ptr = 8'h00;

  always @(negedge soc_clk) begin : slave
    logic line;
    line = sda_t & slv_sda;
    if (pscl && scl_t && psda && !line) begin
      bus_log.push_back(EV_S);
      bitn = 0; bidx = 0; rd_act = 1'b0; slv_sda = 1'b1;
    end else if (pscl && scl_t && !psda && line) begin
      bus_log.push_back(EV_P);
      bitn = 0; rd_act = 1'b0; slv_sda = 1'b1;
    end else if (!pscl && scl_t) begin
      if (bitn < 8) sh = {sh[6:0], line};
      if (bitn == 7) bus_log.push_back(int'(sh));
      if (bitn == 8) begin
        bus_log.push_back(EV_A | int'(line));
        if (rd_act && line) rd_act = 1'b0;
      end
      bitn++;
    end else if (pscl && !scl_t) begin
      if (bitn == 9) begin bitn = 0; bidx++; end
      if (bitn == 8) begin
        if (bidx == 0) begin
          addressed = (sh[7:1] == SLAVE_ADDR);
          slv_sda = !addressed;
          if (addressed && sh[0]) begin rd_act = 1'b1; tx = slave_mem[ptr]; end
        end else if (rd_act) begin
          slv_sda = 1'b1;
        end else if (addressed) begin
          slv_sda = 1'b0;
          if (bidx == 1) ptr = sh; else slave_mem[ptr] = sh;
        end else begin
          slv_sda = 1'b1;
        end
      end else if (bitn < 8 && rd_act) begin
        slv_sda = tx[7 - bitn];
      end else begin
        slv_sda = 1'b1;
      end
    end
    pscl = scl_t;
    psda = line;
  end

  // Transaction-level expectation: bus events, response fields, latency.
  task automatic build_exp(input logic rw, input logic [6:0] dv, input logic [7:0] rg,
                           input logic [7:0] wd, output logic e_nack,
                           output logic [7:0] e_rd, output int e_lat);
    logic hit;
    hit = (dv == SLAVE_ADDR);
    exp_log.delete();
    exp_log.push_back(EV_S);
    exp_log.push_back(int'({dv, 1'b0}));
    exp_log.push_back(EV_A | (hit ? 0 : 1));
    e_nack = !hit;
    e_rd = 8'h00;
    if (!hit) begin
      e_lat = 44 * QDIV + 1;
    end else begin
      exp_log.push_back(int'(rg));
      exp_log.push_back(EV_A);
      if (!rw) begin
        exp_log.push_back(int'(wd));
        exp_log.push_back(EV_A);
        ref_mem[rg] = wd;
        e_lat = 116 * QDIV + 1;
      end else begin
        exp_log.push_back(EV_S);
        exp_log.push_back(int'({dv, 1'b1}));
        exp_log.push_back(EV_A);
        exp_log.push_back(int'(ref_mem[rg]));
        exp_log.push_back(EV_A | 1);
        e_rd = ref_mem[rg];
        e_lat = 156 * QDIV + 1;
      end
    end
    exp_log.push_back(EV_P);
  endtask

  task automatic drive_cmd(input logic rw, input logic [6:0] dv, input logic [7:0] rg,
                           input logic [7:0] wd);
    cmd_rw = rw; cmd_dev_addr = dv; cmd_reg = rg; cmd_wdata = wd;
  endtask

  // Called at negedge with cmd_valid high; returns #1 after the accepting edge.
  task automatic wait_accept(input string tag);
    int i;
    for (i = 0; i < 20 && cmd_ready !== 1'b1; i++) @(negedge soc_clk);
    check_eq({tag, "_ready"}, cmd_ready, 1'b1);
    @(posedge soc_clk); #1;
  endtask

  // Entered #1 after the accept edge, which is cycle 1 of the transaction.
  task automatic finish_check(input string tag, input logic e_nack, input logic [7:0] e_rd,
                              input int e_lat, input bit scramble);
    int cyc;
    cyc = 1;
    while (rsp_valid !== 1'b1 && cyc < 160 * QDIV + 20) begin
      if (scramble) drive_cmd($urandom, $urandom, $urandom, $urandom);
      @(posedge soc_clk); #1;
      cyc++;
    end
    check_eq({tag, "_latency"}, cyc, e_lat);
    check_eq({tag, "_nack"}, rsp_nack, e_nack);
    check_eq({tag, "_rdata"}, rsp_rdata, e_rd);
    check_eq({tag, "_log_len"}, bus_log.size(), exp_log.size());
    for (int i = 0; i < exp_log.size() && i < bus_log.size(); i++)
      check_eq($sformatf("%s_ev%0d", tag, i), bus_log[i], exp_log[i]);
    @(posedge soc_clk); #1;
    check_eq({tag, "_pulse_end"}, rsp_valid, 1'b0);
    check_eq({tag, "_ready_back"}, cmd_ready, 1'b1);
  endtask

  task automatic do_cmd(input string tag, input logic rw, input logic [6:0] dv,
                        input logic [7:0] rg, input logic [7:0] wd);
    logic e_nack;
    logic [7:0] e_rd;
    int e_lat;
    build_exp(rw, dv, rg, wd, e_nack, e_rd, e_lat);
    @(negedge soc_clk);
    bus_log.delete();
    drive_cmd(rw, dv, rg, wd);
    cmd_valid = 1'b1;
    wait_accept(tag);
    cmd_valid = 1'b0;
    finish_check(tag, e_nack, e_rd, e_lat, 1'b0);
  endtask

  task automatic held_test();
    logic e_nack;
    logic [7:0] e_rd;
    int e_lat;
    build_exp(1'b0, SLAVE_ADDR, 8'h5A, 8'hC3, e_nack, e_rd, e_lat);
    @(negedge soc_clk);
    bus_log.delete();
    drive_cmd(1'b0, SLAVE_ADDR, 8'h5A, 8'hC3);
    cmd_valid = 1'b1;
    wait_accept("held_a");
    finish_check("held_a", e_nack, e_rd, e_lat, 1'b1);
    // Now in the IDLE cycle right after the pulse; the coming edge must accept B.
    drive_cmd(1'b1, SLAVE_ADDR, 8'h5A, 8'h00);
    build_exp(1'b1, SLAVE_ADDR, 8'h5A, 8'h00, e_nack, e_rd, e_lat);
    @(posedge soc_clk); #1;
    check_eq("held_b_accept", cmd_ready, 1'b0);
    cmd_valid = 1'b0;
    bus_log.delete();
    finish_check("held_b", e_nack, e_rd, e_lat, 1'b0);
  endtask

  task automatic reset_mid_test();
    int rc;
    @(negedge soc_clk);
    drive_cmd(1'b0, SLAVE_ADDR, 8'h33, 8'h99);
    cmd_valid = 1'b1;
    wait_accept("rst_mid");
    cmd_valid = 1'b0;
    rc = rsp_cnt;
    repeat (50 * QDIV - 2) @(posedge soc_clk);
    @(negedge soc_clk);
    aresetn = 1'b0;
    @(posedge soc_clk); #1;
    check_eq("rst_mid_scl", scl_t, 1'b1);
    check_eq("rst_mid_sda", sda_t, 1'b1);
    check_eq("rst_mid_ready", cmd_ready, 1'b1);
    check_eq("rst_mid_rsp", rsp_valid, 1'b0);
    @(negedge soc_clk);
    aresetn = 1'b1;
    repeat (80 * QDIV) @(posedge soc_clk);
    #1;
    check_eq("rst_mid_no_rsp", rsp_cnt, rc);
    check_eq("rst_mid_idle_ready", cmd_ready, 1'b1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d failures", n_chk, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] dv;
    for (int i = 0; i < 256; i++) begin
      slave_mem[i] = 8'($urandom);
      ref_mem[i] = slave_mem[i];
    end
    slave_mem[8'h0C] = 8'h3C;
    ref_mem[8'h0C] = 8'h3C;

    aresetn = 1'b0;
    repeat (3) @(posedge soc_clk);
    #1;
    check_eq("reset_scl", scl_t, 1'b1);
    check_eq("reset_sda", sda_t, 1'b1);
    check_eq("reset_ready", cmd_ready, 1'b1);
    check_eq("reset_rsp_valid", rsp_valid, 1'b0);
    check_eq("reset_rdata", rsp_rdata, 8'h00);
    check_eq("reset_nack", rsp_nack, 1'b0);
    @(negedge soc_clk);
    aresetn = 1'b1;

    do_cmd("wr", 1'b0, SLAVE_ADDR, 8'h05, 8'hA5);
    do_cmd("rd", 1'b1, SLAVE_ADDR, 8'h0C, 8'h00);
    do_cmd("nack_w", 1'b0, 7'h11, 8'h05, 8'h77);
    do_cmd("nack_r", 1'b1, 7'h55, 8'h0C, 8'h00);
    held_test();
    reset_mid_test();
    do_cmd("post_rst_wr", 1'b0, SLAVE_ADDR, 8'h33, 8'h6E);
    do_cmd("post_rst_rd", 1'b1, SLAVE_ADDR, 8'h33, 8'h00);

    for (int t = 0; t < 10; t++) begin
      dv = SLAVE_ADDR;
      if ($urandom_range(0, 3) == 0) begin
        dv = 7'($urandom_range(0, 127));
        if (dv == SLAVE_ADDR) dv = SLAVE_ADDR + 7'd1;
      end
      do_cmd($sformatf("rnd%0d", t), 1'($urandom_range(0, 1)), dv,
             8'($urandom_range(0, 7)), 8'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_reg_master.md
Name: i2c_reg_master

Overview:
- I2C initiator that performs single-register writes and reads against the system controller's I2C register slave, or any slave using the same protocol: device address, register index, then data.
- Sits in the SoC clock domain behind a simple command/response handshake, for use as a board-management peripheral and as the bench driver for the controller's register file.
- Drives SCL and SDA open-drain through the pad IOBUFs. A pad enable of 1 releases the line (input); 0 drives it low.

Parameters:
- C_QDIV, 63, SCL quarter-period in clock cycles; legal range 2..1023. 63 gives about 99 kHz from 25 MHz.

Ports:
- soc_clk  input  1  block clock.
- aresetn  input  1  synchronous active-low reset.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  high only in IDLE.
- cmd_rw  input  1  0 = write, 1 = read.
- cmd_dev_addr  input  7  7-bit slave address.
- cmd_reg  input  8  register index.
- cmd_wdata  input  8  write data; ignored for reads.
- rsp_valid  output  1  one-cycle completion pulse.
- rsp_rdata  output  8  read data; valid with rsp_valid.
- rsp_nack  output  1  transaction aborted on a slave NACK; valid with rsp_valid.
- scl_t  output  1  SCL pad enable; 1 = released, 0 = pull low.
- sda_t  output  1  SDA pad enable; 1 = released, 0 = pull low.
- sda_i  input  1  SDA pad input.

Behaviour:
- Reset (aresetn low at a soc_clk edge):
  - state = IDLE; scl_t = 1, sda_t = 1; cmd_ready = 1; rsp_valid = 0; rsp_rdata = 0; rsp_nack = 0; tick counter = 0.
  - A reset mid-transaction releases both lines at the next edge with no STOP sent. This is accepted behaviour.
- Command capture:
  - A command is accepted when cmd_valid and cmd_ready are both high at a clock edge.
  - All cmd_* fields are captured at that edge. The tick counter clears, and cmd_ready drops in the following cycle.
- Timing:
  - One quarter (Q) = exactly C_QDIV cycles.
  - Every data or ack bit = 4 Q:
    - Q0: SCL low, SDA updated.
    - Q1: SCL low.
    - Q2: SCL released.
    - Q3: SCL released.
  - sda_i is sampled on the last cycle of Q2.
  - Clock stretching is not supported.
- START: 4 Q.
  - Q0–Q1: SDA released, SCL released.
  - Q2: SDA low.
  - Q3: SCL low.
- Repeated START (RSTART): 4 Q.
  - Q0: SDA released, SCL low.
  - Q1: SCL released.
  - Q2: SDA low.
  - Q3: SCL low.
- STOP: 4 Q.
  - Q0: SDA low, SCL low.
  - Q1: SCL released.
  - Q2: SDA released.
  - Q3: idle-high.
- Bytes are shifted MSB first. In ack bits the master releases SDA; an ack is sda_i = 0.
- Write sequence: IDLE → START → ADDR({dev_addr, 0}) → ACK → REG → ACK → WDATA → ACK → STOP → DONE.
- Read sequence: IDLE → START → ADDR({dev_addr, 0}) → ACK → REG → ACK → RSTART → ADDR({dev_addr, 1}) → ACK → RDATA (SDA released, 8 samples) → MNACK (master releases SDA, i.e. NACK) → STOP → DONE.
- Any slave NACK (sda_i = 1 at an ack sample):
  - Set the nack flag and go straight to STOP, skipping the remaining bytes.
  - rsp_rdata = 0 on NACK.
- DONE lasts one cycle:
  - rsp_valid = 1, with rsp_nack and rsp_rdata valid.
  - Next state is IDLE, where cmd_ready = 1.
  - rsp_valid is never asserted outside DONE.
- Latency from the accept edge to rsp_valid:
  - Write, full: 116 × C_QDIV + 1 cycles.
  - Read, full: 156 × C_QDIV + 1 cycles.
  - Address NACK: 44 × C_QDIV + 1 cycles.
- cmd_valid is ignored while busy. No queueing.
- Counters:
  - Bit counter: 0..7 wraps into the ack phase.
  - Quarter counter: 2 bits.
  - Tick counter: clog2(C_QDIV) bits.

Test Plan:
- Reset with aresetn = 0 for 3 cycles → scl_t = 1, sda_t = 1, cmd_ready = 1, rsp_valid = 0.
- C_QDIV = 4; write dev 0x2A, reg 0x05, data 0xA5; slave model ACKs all three bytes → bus bytes 0x54, 0x05, 0xA5 are seen framed by START/STOP; rsp_valid pulses at cycle 465 after accept; rsp_nack = 0.
- C_QDIV = 4; read dev 0x2A, reg 0x0C; slave returns 0x3C → bus bytes 0x54, 0x0C, RSTART, 0x55, then master NACK and STOP; rsp_rdata = 0x3C; rsp_valid at cycle 625.
- No slave present, so SDA stays high → address NACK, STOP issued; rsp_nack = 1, rsp_rdata = 0, rsp_valid at cycle 44 × 4 + 1 = 177.
- cmd_valid held high through the busy period with changing fields → only the first command is executed; the second is accepted in the cycle after rsp_valid.
- aresetn pulsed low during the REG byte → both lines released next edge, no rsp_valid, cmd_ready = 1; a following write completes normally.
